// File: rtl/stream_demux_1xn.sv
// Packet-aware 1-to-NUM_CH stream demultiplexer with one registered beat per channel.
// Whole packets are steered by the select sampled on their first beat. Packets with an out-of-range select are dropped and counted.
//
// state | meaning
// IDLE  | between packets; next accepted beat is a first beat, s_sel sampled
// ROUTE | packet locked to lock_ch until its last beat
// DROP  | discarding the rest of an out-of-range packet
module stream_demux_1xn #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic [SEL_W-1:0]         s_sel,
    input  logic                     s_last,
    output logic [NUM_CH-1:0]        m_valid,
    input  logic [NUM_CH-1:0]        m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic [NUM_CH-1:0]        m_last,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUTE = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

    logic [1:0]        state;
    logic [SEL_W-1:0]  lock_ch;
    logic [SEL_W-1:0]  route_ch;
    logic [NUM_CH-1:0] route_hot;
    logic [NUM_CH-1:0] ch_free;
    logic [NUM_CH-1:0] load;
    logic              sel_in_range;
    logic              route_free;
    logic              routing;
    logic              accept;
    logic              drop_start;

    assign sel_in_range = ({1'b0, s_sel} < NUM_CH_L);
    assign route_ch     = (state == ROUTE) ? lock_ch : s_sel;
    assign ch_free      = ~m_valid | m_ready;

    always_comb begin
        route_hot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            route_hot[k] = (route_ch == SEL_W'(k));
        end
    end

    assign route_free = |(ch_free & route_hot);

    // s_ready never looks at s_valid, so there is no valid->ready loop.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            IDLE:    s_ready = sel_in_range ? route_free : 1'b1;
            ROUTE:   s_ready = route_free;
            DROP:    s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign routing    = (state == ROUTE) || ((state == IDLE) && sel_in_range);
    assign accept     = s_valid && s_ready;
    assign load       = (accept && routing) ? route_hot : '0;
    assign drop_start = accept && (state == IDLE) && !sel_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_in_range) begin
                            lock_ch <= s_sel;
                            if (!s_last) state <= ROUTE;
                        end else if (!s_last) begin
                            state <= DROP;
                        end
                    end
                end
                ROUTE, DROP: begin
                    if (accept && s_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_start && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Load wins over drain so a ready consumer sustains one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '0;
            m_data  <= '0;
            m_last  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load[k]) begin
                    m_valid[k]                 <= 1'b1;
                    m_data[k*DATA_W +: DATA_W] <= s_data;
                    m_last[k]                  <= s_last;
                end else if (m_ready[k]) begin
                    m_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed bench for stream_demux_1xn: a default 4-channel instance and a
// 3-channel instance with a 2-bit saturating drop counter.
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_last;
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic [3:0]  a_mvalid, a_mready, a_mlast;
    logic [31:0] a_mdata;
    logic [7:0]  a_drop;

    logic        b_valid, b_ready, b_last;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic [2:0]  b_mvalid, b_mready, b_mlast;
    logic [23:0] b_mdata;
    logic [1:0]  b_drop;

    int errors = 0;
    int checks = 0;

    stream_demux_1xn #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_sel(a_sel), .s_last(a_last),
        .m_valid(a_mvalid), .m_ready(a_mready), .m_data(a_mdata), .m_last(a_mlast),
        .drop_cnt(a_drop)
    );

    stream_demux_1xn #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_sel(b_sel), .s_last(b_last),
        .m_valid(b_mvalid), .m_ready(b_mready), .m_data(b_mdata), .m_last(b_mlast),
        .drop_cnt(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        a_valid = v; a_sel = sel; a_data = d; a_last = l;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        b_valid = v; b_sel = sel; b_data = d; b_last = l;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        a_mready = 4'hF;
        b_mready = 3'h7;
        #12;
        chk("rst_mvalid", 32'(a_mvalid), 32'h0);
        chk("rst_mdata", a_mdata, 32'h0);
        chk("rst_mlast", 32'(a_mlast), 32'h0);
        chk("rst_drop", 32'(a_drop), 32'h0);
        chk("rst_sready", 32'(a_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        // single-beat packets to every channel
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 2'(k), 8'hA0 + 8'(k), 1'b1);
            #1;
            chk("single_sready", 32'(a_ready), 32'h1);
            tick();
            chk("single_mvalid", 32'(a_mvalid), 32'(1) << k);
            chk("single_mdata", 32'(a_mdata[k*8 +: 8]), 32'hA0 + 32'(k));
            chk("single_mlast", 32'(a_mlast[k]), 32'h1);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("single_pulse_end", 32'(a_mvalid), 32'h0);

        // 4-beat packet to channel 2, select toggled after first beat
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, (i == 0) ? 2'd2 : 2'd1, 8'h10 + 8'(i), i == 3);
            #1;
            chk("pkt4_sready", 32'(a_ready), 32'h1);
            tick();
            chk("pkt4_mvalid", 32'(a_mvalid), 32'h4);
            chk("pkt4_mdata", 32'(a_mdata[23:16]), 32'h10 + 32'(i));
            chk("pkt4_mlast", 32'(a_mlast[2]), (i == 3) ? 32'h1 : 32'h0);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("pkt4_end", 32'(a_mvalid), 32'h0);

        // back-pressure on channel 3 with a pending beat on channel 0
        a_mready = 4'b0110;
        drive_a(1'b1, 2'd0, 8'h55, 1'b1);
        tick();
        chk("bp_ch0_load", 32'(a_mvalid), 32'h1);
        drive_a(1'b1, 2'd3, 8'h30, 1'b0);
        #1;
        chk("bp_beat1_sready", 32'(a_ready), 32'h1);
        tick();
        chk("bp_beat1_mvalid", 32'(a_mvalid), 32'h9);
        chk("bp_beat1_mdata", 32'(a_mdata[31:24]), 32'h30);
        drive_a(1'b1, 2'd0, 8'h31, 1'b0);
        #1;
        chk("bp_stall_sready", 32'(a_ready), 32'h0);
        a_mready = 4'b0111;
        tick();
        chk("bp_ch0_drained", 32'(a_mvalid), 32'h8);
        chk("bp_ch3_held", 32'(a_mdata[31:24]), 32'h30);
        chk("bp_still_stalled", 32'(a_ready), 32'h0);
        a_mready = 4'hF;
        #1;
        chk("bp_release_sready", 32'(a_ready), 32'h1);
        tick();
        chk("bp_beat2_mdata", 32'(a_mdata[31:24]), 32'h31);
        chk("bp_beat2_mvalid", 32'(a_mvalid), 32'h8);
        drive_a(1'b1, 2'd1, 8'h32, 1'b1);
        tick();
        chk("bp_beat3_mdata", 32'(a_mdata[31:24]), 32'h32);
        chk("bp_beat3_mlast", 32'(a_mlast[3]), 32'h1);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("bp_end", 32'(a_mvalid), 32'h0);

        // saturating 2-bit drop counter: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            drive_b(1'b1, 2'd3, 8'hD0 + 8'(i), 1'b1);
            #1;
            chk("sat_sready", 32'(b_ready), 32'h1);
            tick();
            chk("sat_drop", 32'(b_drop), (i < 3) ? 32'(i + 1) : 32'h3);
            chk("sat_mvalid", 32'(b_mvalid), 32'h0);
        end
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);

        rst_n = 1'b0;
        #1;
        chk("rst2_drop", 32'(b_drop), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2-beat out-of-range packet, then a real beat to channel 0
        drive_b(1'b1, 2'd3, 8'hE0, 1'b0);
        #1;
        chk("drop_b1_sready", 32'(b_ready), 32'h1);
        tick();
        chk("drop_b1_cnt", 32'(b_drop), 32'h1);
        chk("drop_b1_mvalid", 32'(b_mvalid), 32'h0);
        drive_b(1'b1, 2'd0, 8'hEE, 1'b1);
        #1;
        chk("drop_b2_sready", 32'(b_ready), 32'h1);
        tick();
        chk("drop_b2_mvalid", 32'(b_mvalid), 32'h0);
        chk("drop_b2_cnt", 32'(b_drop), 32'h1);
        drive_b(1'b1, 2'd0, 8'h77, 1'b1);
        tick();
        chk("drop_ch0_mvalid", 32'(b_mvalid), 32'h1);
        chk("drop_ch0_mdata", 32'(b_mdata[7:0]), 32'h77);
        chk("drop_ch0_cnt", 32'(b_drop), 32'h1);
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        tick();

        // reset in the middle of a stalled packet to channel 1
        a_mready = 4'b1101;
        drive_a(1'b1, 2'd1, 8'h40, 1'b0);
        tick();
        chk("mid_beat1_mvalid", 32'(a_mvalid), 32'h2);
        drive_a(1'b1, 2'd1, 8'h41, 1'b0);
        #1;
        chk("mid_stall_sready", 32'(a_ready), 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mvalid", 32'(a_mvalid), 32'h0);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_a(1'b1, 2'd2, 8'h99, 1'b1);
        #1;
        chk("post_rst_sready", 32'(a_ready), 32'h1);
        tick();
        chk("post_rst_mvalid", 32'(a_mvalid), 32'h4);
        chk("post_rst_mdata", 32'(a_mdata[23:16]), 32'h99);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1xn.md
# stream_demux_1xn

Packet-aware, parametrised 1-to-NUM_CH stream demultiplexer with valid/ready handshaking on the input and on every output channel. It is the registered successor of the combinational 1x4 demux: it routes whole packets, latches the channel select at the first beat, holds it until the last beat, and buffers one beat per channel. Packets whose select is out of range are dropped and counted. It sits between a single producer and NUM_CH independent consumers in the datapath.

## Interface
Parameters:
- DATA_W, 8, payload width per beat.
- NUM_CH, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH.
- CNT_W, 8, drop-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input payload.
- s_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- s_last  in  1  marks the final beat of a packet.
- m_valid  out  NUM_CH  per-channel output valid (registered).
- m_ready  in  NUM_CH  per-channel consumer ready.
- m_data  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W] (registered).
- m_last  out  NUM_CH  per-channel last flag (registered).
- drop_cnt  out  CNT_W  count of dropped packets, saturating.

## Operation
- FSM states: IDLE (between packets), ROUTE (packet locked to lock_ch), DROP (discarding an out-of-range packet).
- Each channel k has one output register (m_data, m_last, m_valid). It is free when !m_valid[k] || m_ready[k]. A channel's output register is loaded only by an accepted beat routed to it. Otherwise, m_valid[k] clears when m_valid[k] && m_ready[k].
- IDLE, s_sel < NUM_CH: s_ready = channel s_sel free. On acceptance, load channel s_sel and set lock_ch = s_sel. If s_last = 0, go to ROUTE; otherwise stay in IDLE.
- IDLE, s_sel >= NUM_CH: s_ready = 1. The beat is discarded and drop_cnt increments by 1, saturating at 2**CNT_W-1. If s_last = 0, go to DROP.
- ROUTE: s_sel is ignored and s_ready = channel lock_ch free. Accepted beats load channel lock_ch. An accepted beat with s_last = 1 returns the FSM to IDLE.
- DROP: s_ready = 1 and all beats are discarded. drop_cnt does not increment. An accepted beat with s_last = 1 returns the FSM to IDLE.
- Channels not addressed by the current beat keep their state and drain independently. Back-pressure on one channel never stalls the draining of another.
- m_data and m_last hold their value while m_valid = 0; their content is don't-care to the bench.

## Timing
- Reset (rst_n = 0, asynchronous): m_valid = 0, m_data = 0, m_last = 0, drop_cnt = 0, FSM = IDLE, lock_ch = 0. s_ready then follows its combinational rule from the reset state.
- Reset mid-packet: beats held in the output registers are lost. After rst_n rises, the next accepted beat is treated as a first beat and s_sel is sampled.
- Latency: a beat accepted at edge N appears on m_valid/m_data/m_last from edge N onward, i.e. visible in cycle N+1. Latency is 1 cycle.
- Throughput: 1 beat/cycle into a channel whose consumer holds m_ready = 1. This works because load and drain happen in the same cycle.
- s_ready is combinational from FSM state, lock_ch, s_sel (in IDLE only), m_valid and m_ready. There is no combinational path from s_valid to s_ready.
- Single-beat packet (first beat with s_last = 1): handled entirely in IDLE with no state change.
- Out-of-range packets: drop_cnt updates at the acceptance edge of the first beat.

## Test plan
- Reset with all m_ready = 1: send single-beat packets with s_sel = 0,1,2,3 and data 0xA0..0xA3. Each m_valid[k] pulses for 1 cycle carrying 0xA0+k, one cycle after its acceptance, with m_last = 1.
- 4-beat packet to channel 2 (data 0x10..0x13), with s_sel toggled to 1 on beats 2-4. All four beats exit channel 2 back-to-back; channel 1 stays idle.
- Hold m_ready[3] = 0 and send a 3-beat packet to channel 3. s_ready drops after beat 1 is accepted. Meanwhile a pending beat on channel 0 drains normally. Releasing m_ready[3] completes the packet in order.
- NUM_CH = 3, SEL_W = 2: send a 2-beat packet with s_sel = 3, then a 1-beat packet to channel 0. s_ready stays 1, drop_cnt reads 1, and only the channel-0 beat appears.
- CNT_W = 2: send 5 out-of-range packets. drop_cnt goes 1, 2, 3, 3, 3.
- Assert rst_n = 0 after beat 2 of a 4-beat packet to channel 1 that has m_ready = 0. m_valid clears immediately. After release, a new packet with s_sel = 2 routes to channel 2.
